gate_unit_arbiter: RTL and testbench



---
 rtl/gate_unit_arbiter.sv | 148 ++++++++++++++
 tb/tb_gate_unit_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
// Shares one registered NOT/AND/OR/XOR gate unit among N_REQ requesters.
// A round-robin search picks one requester, its opcode and operands are
// latched, the result is computed from the latched copy, and a registered
// result is returned with a one-cycle done pulse. One operation per 3 cycles.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   req   level request per requester
//   op    2-bit opcode per requester (00 NOT a, 01 AND, 10 OR, 11 XOR)
//   a, b  operands per requester, WIDTH bits each, requester i at [WIDTH*i +: WIDTH]
//   gnt   one-hot grant pulse, marks operand capture
//   done  one-hot completion pulse, res valid
//   res   result of the last completed operation, held until the next done
//   busy  high while a transaction is in flight
module gate_unit_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a,
    input  logic [WIDTH*N_REQ-1:0] b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       res,
    output logic                   busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [N_REQ-1:0]   gnt_d, done_d;
    logic [WIDTH-1:0]   res_d;
    logic               busy_d;

    // Round-robin search: start at last+1 and wrap, first requester wins.
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [1:0]         win_op;
    logic [WIDTH-1:0]   win_a, win_b;
    int unsigned        idx;

    always_comb begin
        found  = 1'b0;
        win    = '0;
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (32'(last_q) + k) % N_REQ;
            if (!found && req[idx[IDX_W-1:0]]) begin
                found  = 1'b1;
                win    = idx[IDX_W-1:0];
                win_op = op[2*idx +: 2];
                win_a  = a[WIDTH*idx +: WIDTH];
                win_b  = b[WIDTH*idx +: WIDTH];
            end
        end
    end

    logic [WIDTH-1:0] gate_out;

    always_comb begin
        gate_out = '0;
        unique case (op_q)
            2'b00: gate_out = ~a_q;
            2'b01: gate_out = a_q & b_q;
            2'b10: gate_out = a_q | b_q;
            2'b11: gate_out = a_q ^ b_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt_d   = '0;
        done_d  = '0;
        res_d   = res;
        busy_d  = busy;
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (found) begin
                    state_d     = StExec;
                    last_d      = win;
                    op_d        = win_op;
                    a_d         = win_a;
                    b_d         = win_b;
                    gnt_d[win]  = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            StExec: begin
                state_d        = StDone;
                res_d          = gate_out;
                done_d[last_q] = 1'b1;
                busy_d         = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            last_q  <= LAST_RST;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gnt     <= '0;
            done    <= '0;
            res     <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt     <= gnt_d;
            done    <= done_d;
            res     <= res_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
module tb_gate_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [2*N-1:0]   op;
    logic [W*N-1:0]   a, b;
    logic [N-1:0]     gnt, done;
    logic [W-1:0]     res;
    logic             busy;

    gate_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .op   (op),
        .a    (a),
        .b    (b),
        .gnt  (gnt),
        .done (done),
        .res  (res),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model: cycles since grant (0 = idle), owner, pending result.
    int           m_age;
    int           m_last;
    int           m_owner;
    logic [W-1:0] m_pending;
    logic [N-1:0] e_gnt, e_done;
    logic [W-1:0] e_res;
    logic         e_busy;

    function automatic logic [W-1:0] gate_fn(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
        case (o)
            2'b00:   return ~x;
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age   = 0;
        m_last  = N - 1;
        m_owner = 0;
        m_pending = '0;
        e_gnt = '0; e_done = '0; e_res = '0; e_busy = 1'b0;
    endtask

    // Advance the model over one rising edge using the inputs now applied.
    task automatic model_step();
        e_gnt  = '0;
        e_done = '0;
        if (m_age == 0) begin
            e_busy = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_last + k) % N;
                if (m_age == 0 && req[i]) begin
                    m_owner   = i;
                    m_last    = i;
                    m_pending = gate_fn(op[2*i +: 2], a[W*i +: W], b[W*i +: W]);
                    e_gnt[i]  = 1'b1;
                    e_busy    = 1'b1;
                    m_age     = 1;
                end
            end
        end else if (m_age == 1) begin
            e_done[m_owner] = 1'b1;
            e_res  = m_pending;
            e_busy = 1'b1;
            m_age  = 2;
        end else begin
            e_busy = 1'b0;
            m_age  = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("gnt",  32'(gnt),  32'(e_gnt));
        chk("done", 32'(done), 32'(e_done));
        chk("res",  32'(res),  32'(e_res));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic set_req(int i, logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
        op[2*i +: 2] = o;
        a[W*i +: W]  = x;
        b[W*i +: W]  = y;
    endtask

    logic [1:0] fop [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [W-1:0] fexp [4] = '{8'h88, 8'hEE, 8'h66, 8'h55};
    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1;
        req = '0; op = '0; a = '0; b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_res", 32'(res), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();

        // Single NOT on requester 0.
        req = 4'b0001;
        set_req(0, 2'b00, 8'h0F, 8'h33);
        tick();
        chk("not_gnt", 32'(gnt), 32'h1);
        req = '0;
        tick();
        chk("not_done", 32'(done), 32'h1);
        chk("not_res", 32'(res), 32'hF0);
        tick();
        chk("not_busy", 32'(busy), 32'h0);

        // Function coverage on requester 2.
        for (int f = 0; f < 4; f++) begin
            set_req(2, fop[f], 8'hAA, 8'hCC);
            req = 4'b0100;
            tick();
            req = '0;
            tick();
            chk("func_res", 32'(res), 32'(fexp[f]));
            tick();
        end

        // Reset asserted while the operation is executing.
        set_req(0, 2'b01, 8'hFF, 8'hFF);
        req = 4'b0001;
        tick();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_res", 32'(res), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 req = '0;
        rst = 1'b0;
        repeat (3) tick();

        // Round-robin with all requesting.
        for (int i = 0; i < N; i++) set_req(i, 2'(i), 8'(8'h11 * (i + 1)), 8'(8'h0F << i));
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("rr_gnt", 32'(gnt), 32'(1 << rr_exp[t]));
            tick();
            chk("rr_res", 32'(res),
                32'(gate_fn(2'(rr_exp[t]), 8'(8'h11 * (rr_exp[t] + 1)), 8'(8'h0F << rr_exp[t]))));
            tick();
        end
        req = '0;
        tick();

        // Fairness: after requester 1, a 0/1 pair resolves to 0 then 1.
        req = 4'b0010;
        tick();
        chk("fair_g1", 32'(gnt), 32'h2);
        req = 4'b0011;
        tick(); tick();
        tick();
        chk("fair_g0", 32'(gnt), 32'h1);
        tick(); tick();
        tick();
        chk("fair_g1b", 32'(gnt), 32'h2);
        req = '0;
        tick(); tick(); tick();

        // Operand stability after capture.
        set_req(2, 2'b11, 8'hFF, 8'h0F);
        req = 4'b0100;
        tick();
        chk("stab_gnt", 32'(gnt), 32'h4);
        a[W*2 +: W] = 8'h00;
        req = '0;
        tick();
        chk("stab_done", 32'(done), 32'h4);
        chk("stab_res", 32'(res), 32'hF0);
        tick();
        tick();
        chk("stab_nogrant", 32'(gnt), 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req = '0;
            op = 8'($urandom);
            a  = $urandom;
            b  = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
